// File: rtl/seed_pass_ctrl_pkg.sv
// Shared read/seek definitions: symbol encoding, position width, pass and FSM types.
package BwaMemDefines;

  localparam int GD_READ_LEN_MAX = 78;
  localparam int POS_W = $clog2(GD_READ_LEN_MAX + 1);
  localparam int CALL_CNT_W = 8;

  typedef logic [2:0] Symbol;
  localparam Symbol sym_A = 3'd0;
  localparam Symbol sym_C = 3'd1;
  localparam Symbol sym_G = 3'd2;
  localparam Symbol sym_T = 3'd3;
  localparam Symbol sym_N = 3'd4;

  typedef enum logic {PassSmem, PassSf} SeedPass;

  typedef enum logic [2:0] {
    S_Idle,
    S_Check,
    S_Start,
    S_Wait,
    S_Advance,
    S_Done
  } seed_state_t;

  function automatic logic [CALL_CNT_W-1:0] sat_inc(input logic [CALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/seed_pass_ctrl.sv
// Schedules seek-engine calls across a read: bi-directional pass, optional forward pass.
// state     | meaning
// S_Idle    | waiting for a job; job_ready high
// S_Check   | end-of-pass test, skip N bases, or issue a call
// S_Start   | one-cycle start pulse to the seek engine
// S_Wait    | engine running; hold pos/bi_dir until finish
// S_Advance | move pos forward, at least by one
// S_Done    | one-cycle completion pulse
module seed_pass_ctrl
  import BwaMemDefines::*;
#(
  parameter int GD_READ_LEN = GD_READ_LEN_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  Symbol                 gd_read [0:GD_READ_LEN-1],
  input  logic [POS_W-1:0]      read_len,
  input  logic                  sf_en,
  input  logic                  job_valid,
  output logic                  job_ready,
  output logic [POS_W-1:0]      seek_pos,
  output logic                  seek_bi_dir,
  output logic                  seek_start,
  input  logic                  seek_finish,
  input  logic [POS_W-1:0]      seek_pos_out,
  output logic                  done,
  output logic                  busy,
  output logic [CALL_CNT_W-1:0] call_cnt
);

  localparam int PW = POS_W + 1;

  seed_state_t           state_q, state_d;
  logic [PW-1:0]         pos_q, pos_d;
  SeedPass               pass_q, pass_d;
  logic [CALL_CNT_W-1:0] call_cnt_q, call_cnt_d;
  logic                  sf_en_q;
  logic [POS_W-1:0]      read_len_q;
  logic [POS_W-1:0]      pos_out_q;
  Symbol                 read_q [0:GD_READ_LEN-1];
  logic                  load;

  logic end_of_pass;
  logic is_n;

  // pos is one bit wider than read_len so pos+1 never wraps at the last symbol
  assign end_of_pass = pos_q >= {1'b0, read_len_q};
  assign is_n = !end_of_pass && (read_q[pos_q[POS_W-1:0]] == sym_N);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    pass_d     = pass_q;
    call_cnt_d = call_cnt_q;
    load       = 1'b0;
    case (state_q)
      S_Idle: begin
        if (job_valid) begin
          load       = 1'b1;
          pos_d      = '0;
          pass_d     = PassSmem;
          call_cnt_d = '0;
          state_d    = S_Check;
        end
      end
      S_Check: begin
        if (end_of_pass) begin
          if (pass_q == PassSmem && sf_en_q) begin
            pass_d = PassSf;
            pos_d  = '0;
          end else begin
            state_d = S_Done;
          end
        end else if (is_n) begin
          pos_d = pos_q + 1'b1;
        end else begin
          state_d = S_Start;
        end
      end
      S_Start: begin
        call_cnt_d = sat_inc(call_cnt_q);
        state_d    = S_Wait;
      end
      S_Wait: begin
        if (seek_finish) state_d = S_Advance;
      end
      S_Advance: begin
        // an engine that reports no progress must not stall the pass
        if ({1'b0, pos_out_q} > pos_q) pos_d = {1'b0, pos_out_q};
        else                           pos_d = pos_q + 1'b1;
        state_d = S_Check;
      end
      S_Done:  state_d = S_Idle;
      default: state_d = S_Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_Idle;
      pos_q      <= '0;
      pass_q     <= PassSmem;
      call_cnt_q <= '0;
      sf_en_q    <= 1'b0;
      read_len_q <= '0;
      pos_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      pass_q     <= pass_d;
      call_cnt_q <= call_cnt_d;
      if (load) begin
        sf_en_q    <= sf_en;
        read_len_q <= read_len;
      end
      if (state_q == S_Wait && seek_finish) pos_out_q <= seek_pos_out;
    end
  end

  always_ff @(posedge clk) begin
    if (load) read_q <= gd_read;
  end

  assign job_ready   = (state_q == S_Idle);
  assign busy        = (state_q != S_Idle);
  assign seek_start  = (state_q == S_Start);
  assign done        = (state_q == S_Done);
  assign seek_pos    = pos_q[POS_W-1:0];
  assign seek_bi_dir = busy && (pass_q == PassSmem);
  assign call_cnt    = call_cnt_q;

endmodule
